// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values and fixed pc constants.
package cp0_pkg;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;

endpackage

// File: rtl/cp0_exc_ctrl.sv
// M-stage CP0: holds SR/Cause/EPC, decides interrupt/exception entry and serves mfc0/mtc0/eret.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h0000_0000,
  parameter int          HW_INT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_m,
  input  logic [4:0]          exc_m,
  input  logic                slot_m,
  input  logic                eret_m,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                we,
  input  logic [4:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [31:0]         epc_out,
  output logic                req,
  output logic                exl
);

  logic [HW_INT_W-1:0] sr_im;
  logic                sr_exl;
  logic                sr_ie;
  logic                cause_bd;
  logic [HW_INT_W-1:0] cause_ip;
  logic [4:0]          cause_exc;
  logic [31:0]         epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // req is a one-cycle flush pulse with no back-pressure: every stage register
  // that sees it loads a bubble at the same edge CP0 records the entry.
  always_comb begin
    int_req = !sr_exl && sr_ie && (|(sr_im & hw_int));
    exc_req = !sr_exl && (exc_m != EXC_INT);
    req     = int_req || exc_req;
  end

  assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
  assign exl        = sr_exl;

  always_comb begin
    rdata = 32'h0;
    case (addr)
      ADDR_SR:    rdata = sr_word;
      ADDR_CAUSE: rdata = cause_word;
      ADDR_EPC:   rdata = epc;
      ADDR_PRID:  rdata = PRID_VAL;
      default:    rdata = 32'h0;
    endcase
  end

  // Forward an in-flight mtc0 EPC so an eret right behind it needs no stall.
  assign epc_out = (we && (addr == ADDR_EPC) && !req) ? wdata : epc;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= EXC_INT;
      epc       <= 32'h0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= slot_m;
        epc       <= slot_m ? (pc_m - 32'd4) : pc_m;
        cause_exc <= int_req ? EXC_INT : exc_m;
      end else begin
        if (eret_m) begin
          sr_exl <= 1'b0;
        end
        if (we) begin
          case (addr)
            ADDR_SR: begin
              sr_im  <= wdata[15:10];
              sr_exl <= wdata[1];
              sr_ie  <= wdata[0];
            end
            ADDR_EPC: epc <= wdata;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: word-level CP0 model checked every cycle plus literal pins.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_m;
  logic [4:0]  exc_m;
  logic        slot_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] epc_out;
  logic        req;
  logic        exl;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state as whole architectural words
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  cp0_exc_ctrl #(.PRID_VAL(32'h0000_0000), .HW_INT_W(6)) dut (
    .clk(clk), .rst(rst), .pc_m(pc_m), .exc_m(exc_m), .slot_m(slot_m),
    .eret_m(eret_m), .hw_int(hw_int), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .epc_out(epc_out), .req(req), .exl(exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic m_int_req();
    logic [5:0] im;
    im = m_sr[15:10];
    return !m_sr[1] && m_sr[0] && ((im & hw_int) != 6'b0);
  endfunction

  function automatic logic m_req();
    return m_int_req() || (!m_sr[1] && exc_m != 5'd0);
  endfunction

  function automatic logic [31:0] m_rdata();
    case (addr)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_0000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic r;
    logic ir;
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
      return;
    end
    r  = m_req();
    ir = m_int_req();
    m_cause[15:10] = hw_int;
    if (r) begin
      m_sr[1]       = 1'b1;
      m_cause[31]   = slot_m;
      m_epc         = slot_m ? pc_m - 32'd4 : pc_m;
      m_cause[6:2]  = ir ? 5'd0 : exc_m;
    end else begin
      if (eret_m) m_sr[1] = 1'b0;
      if (we && addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
      if (we && addr == 5'd14) m_epc = wdata;
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic exp_req;
    @(negedge clk);
    exp_req = m_req();
    check("req", {31'b0, req}, {31'b0, exp_req});
    check("exl", {31'b0, exl}, {31'b0, m_sr[1]});
    check("rdata", rdata, m_rdata());
    check("epc_out", epc_out, (we && addr == 5'd14 && !exp_req) ? wdata : m_epc);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    exc_m = 0; slot_m = 0; eret_m = 0; we = 0; wdata = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; addr = a; wdata = d;
    cycle();
    we = 0; wdata = 0;
  endtask

  initial begin
    rst = 1; pc_m = 32'h0000_3000; hw_int = 0; addr = 0;
    idle_inputs();
    m_sr = 0; m_cause = 0; m_epc = 0;
    @(posedge clk);
    model_edge();
    #1;
    rst = 0;

    // Reset state
    for (int a = 12; a <= 16; a++) begin
      addr = 5'(a);
      #1 check("reset_rdata", rdata, 32'h0);
      check("reset_req", {31'b0, req}, 32'h0);
      check("reset_exl", {31'b0, exl}, 32'h0);
      cycle();
    end

    // mtc0 to Cause and PRId is ignored
    mtc0(5'd13, 32'hFFFF_FFFF);
    mtc0(5'd15, 32'hFFFF_FFFF);
    addr = 5'd13;
    #1 check("cause_write_ignored", rdata, 32'h0);
    cycle();

    // Enabled interrupt on line 0
    hw_int = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    pc_m = 32'h0000_3004; addr = 5'd12;
    #1 check("int_req", {31'b0, req}, 32'h1);
    check("sr_readback", rdata, 32'h0000_0401);
    cycle();
    pc_m = 32'h0000_3008; addr = 5'd13;
    #1 check("int_cause", rdata, 32'h0000_0400);
    check("int_exl", {31'b0, exl}, 32'h1);
    check("int_masked", {31'b0, req}, 32'h0);
    cycle();
    addr = 5'd14;
    #1 check("int_epc", rdata, 32'h0000_3004);
    cycle();
    hw_int = 0;
    mtc0(5'd12, 32'h0000_0000);

    // Overflow in delay slot
    exc_m = 5'd12; slot_m = 1; pc_m = 32'h0000_3010;
    #1 check("ov_req", {31'b0, req}, 32'h1);
    cycle();
    idle_inputs(); addr = 5'd14;
    #1 check("ov_epc", rdata, 32'h0000_300C);
    cycle();
    addr = 5'd13;
    #1 check("ov_cause", rdata, 32'h8000_0030);
    cycle();
    eret_m = 1;
    cycle();
    eret_m = 0;
    #1 check("eret_exl", {31'b0, exl}, 32'h0);

    // Interrupt beats RI; concurrent mtc0 EPC discarded
    mtc0(5'd12, 32'h0000_0801);
    hw_int = 6'b000010; exc_m = 5'd10; pc_m = 32'h0000_3020;
    we = 1; addr = 5'd14; wdata = 32'h0000_1234;
    #1 check("prio_req", {31'b0, req}, 32'h1);
    check("prio_epc_out", epc_out, 32'h0000_300C);
    cycle();
    idle_inputs(); addr = 5'd14;
    #1 check("prio_epc", rdata, 32'h0000_3020);
    cycle();
    addr = 5'd13;
    #1 check("prio_cause", rdata, 32'h0000_0800);
    cycle();

    // mtc0 EPC with eret in the same cycle
    we = 1; addr = 5'd14; wdata = 32'h0000_3100; eret_m = 1;
    #1 check("bypass_epc_out", epc_out, 32'h0000_3100);
    cycle();
    idle_inputs(); hw_int = 0;
    #1 check("bypass_exl", {31'b0, exl}, 32'h0);
    check("bypass_epc", rdata, 32'h0000_3100);
    cycle();

    // Reset during an exception with interrupt still active
    hw_int = 6'b000010;
    cycle();
    rst = 1;
    cycle();
    rst = 0; addr = 5'd12;
    #1 check("rst_sr", rdata, 32'h0);
    check("rst_exl", {31'b0, exl}, 32'h0);
    check("rst_req", {31'b0, req}, 32'h0);
    cycle();
    addr = 5'd14;
    #1 check("rst_epc", rdata, 32'h0);
    cycle();
    addr = 5'd13;
    #1 check("rst_ip_recapture", rdata, 32'h0000_0800);
    cycle();
    addr = 5'd15;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
